// File: rtl/pin_driver.sv
// Pin output stage: static levels, polarity, step-pulse generators and latched shutdown, configured over Wishbone.
// Optional per-channel step counters at addresses 8+k are enabled by defining PIN_DRIVER_STEP_COUNT_EN.
module pin_driver #(
    parameter int NUM_PINS = 8,
    parameter int NUM_STEP = 2,
    parameter int PW_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_STEP-1:0] step_pulse,
    input  logic                pin_shutdown,
    output logic [NUM_PINS-1:0] pins_out,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } step_state_e;

    localparam logic [PW_W-1:0] PW_ONE = PW_W'(1);

    logic [NUM_PINS-1:0] polarity_q, polarity_d;
    logic [NUM_PINS-1:0] static_q, static_d;
    logic [NUM_PINS-1:0] safe_q, safe_d;
    logic [NUM_PINS-1:0] pins_q, pins_d;
    logic [NUM_PINS-1:0] raw;
    logic [PW_W-1:0]     pw_q, pw_d;
    logic [PW_W-1:0]     reload;
    logic                shutdown_q, shutdown_d;
    logic [NUM_STEP-1:0] overflow_q, overflow_d;
    logic [NUM_STEP-1:0] pending_q, pending_d;
    logic [NUM_STEP-1:0] step_out, busy, enter_high;
    step_state_e         state_q [NUM_STEP];
    step_state_e         state_d [NUM_STEP];
    logic [PW_W-1:0]     cnt_q [NUM_STEP];
    logic [PW_W-1:0]     cnt_d [NUM_STEP];
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                req, wr_en, stat_wr;
    logic                unused_wb_dat;
`ifdef PIN_DRIVER_STEP_COUNT_EN
    logic [31:0]         scnt_q [NUM_STEP];
    logic [31:0]         scnt_d [NUM_STEP];
`endif

    assign unused_wb_dat = ^wb_dat_i;

    always_comb begin : bus_decode
        req     = wb_stb_i & wb_cyc_i & ~ack_q;
        wr_en   = req & wb_we_i;
        stat_wr = wr_en && (wb_adr_i == 4'd3);
    end

    always_comb begin : reg_next
        polarity_d = polarity_q;
        static_d   = static_q;
        pw_d       = pw_q;
        safe_d     = safe_q;
        if (wr_en) begin
            case (wb_adr_i)
                4'd0:    polarity_d = wb_dat_i[NUM_PINS-1:0];
                4'd1:    static_d   = wb_dat_i[NUM_PINS-1:0];
                4'd2:    pw_d       = wb_dat_i[PW_W-1:0];
                4'd4:    safe_d     = wb_dat_i[NUM_PINS-1:0];
                default: ;
            endcase
        end
        // A new shutdown request outranks a simultaneous clear.
        shutdown_d = pin_shutdown | (shutdown_q & ~(stat_wr & wb_dat_i[0]));
    end

    always_comb begin : read_next
        ack_d = req;
        dat_d = '0;
        if (req) begin
            case (wb_adr_i)
                4'd0: dat_d[NUM_PINS-1:0] = polarity_q;
                4'd1: dat_d[NUM_PINS-1:0] = static_q;
                4'd2: dat_d[PW_W-1:0]     = pw_q;
                4'd3: begin
                    dat_d[0]             = shutdown_q;
                    dat_d[8 +: NUM_STEP]  = overflow_q;
                    dat_d[16 +: NUM_STEP] = busy;
                end
                4'd4: dat_d[NUM_PINS-1:0] = safe_q;
                default: ;
            endcase
`ifdef PIN_DRIVER_STEP_COUNT_EN
            for (int unsigned k = 0; k < NUM_STEP; k++) begin
                if (wb_adr_i == 4'(8 + k)) dat_d = scnt_q[k];
            end
`endif
        end
    end

    always_comb begin : step_outputs
        for (int unsigned k = 0; k < NUM_STEP; k++) begin
            step_out[k] = (state_q[k] == ST_HIGH);
            busy[k]     = (state_q[k] != ST_IDLE);
        end
    end

    always_comb begin : step_next
        reload = (pw_q == '0) ? '0 : pw_q - PW_ONE;
        for (int unsigned k = 0; k < NUM_STEP; k++) begin
            state_d[k]    = state_q[k];
            cnt_d[k]      = cnt_q[k];
            pending_d[k]  = pending_q[k];
            overflow_d[k] = overflow_q[k] & ~(stat_wr & wb_dat_i[8 + k]);
            enter_high[k] = 1'b0;
            if (shutdown_d) begin
                state_d[k]   = ST_IDLE;
                cnt_d[k]     = '0;
                pending_d[k] = 1'b0;
            end else begin
                case (state_q[k])
                    ST_IDLE: begin
                        if (step_pulse[k]) begin
                            state_d[k]    = ST_HIGH;
                            cnt_d[k]      = reload;
                            enter_high[k] = 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_q[k] == '0) begin
                            state_d[k] = ST_LOW;
                            cnt_d[k]   = reload;
                        end else begin
                            cnt_d[k] = cnt_q[k] - PW_ONE;
                        end
                        if (step_pulse[k]) begin
                            if (pending_q[k]) overflow_d[k] = 1'b1;
                            else              pending_d[k]  = 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_q[k] == '0) begin
                            // A step arriving as the gap ends is served directly; with a pending
                            // step it becomes the new pending one.
                            if (pending_q[k] | step_pulse[k]) begin
                                state_d[k]    = ST_HIGH;
                                cnt_d[k]      = reload;
                                enter_high[k] = 1'b1;
                                pending_d[k]  = pending_q[k] & step_pulse[k];
                            end else begin
                                state_d[k] = ST_IDLE;
                            end
                        end else begin
                            cnt_d[k] = cnt_q[k] - PW_ONE;
                            if (step_pulse[k]) begin
                                if (pending_q[k]) overflow_d[k] = 1'b1;
                                else              pending_d[k]  = 1'b1;
                            end
                        end
                    end
                    default: state_d[k] = ST_IDLE;
                endcase
            end
        end
    end

`ifdef PIN_DRIVER_STEP_COUNT_EN
    always_comb begin : count_next
        for (int unsigned k = 0; k < NUM_STEP; k++) begin
            scnt_d[k] = scnt_q[k] + {31'b0, enter_high[k]};
            if (wr_en && (wb_adr_i == 4'(8 + k))) scnt_d[k] = wb_dat_i;
        end
    end
`endif

    always_comb begin : pins_next
        raw = static_q;
        for (int unsigned k = 0; k < NUM_STEP; k++) begin
            raw[k] = static_q[k] | step_out[k];
        end
        pins_d = shutdown_d ? safe_q : (raw ^ polarity_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            polarity_q <= '0;
            static_q   <= '0;
            safe_q     <= '0;
            pw_q       <= '0;
            shutdown_q <= 1'b0;
            overflow_q <= '0;
            pending_q  <= '0;
            pins_q     <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            for (int unsigned k = 0; k < NUM_STEP; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
`ifdef PIN_DRIVER_STEP_COUNT_EN
                scnt_q[k]  <= '0;
`endif
            end
        end else begin
            polarity_q <= polarity_d;
            static_q   <= static_d;
            safe_q     <= safe_d;
            pw_q       <= pw_d;
            shutdown_q <= shutdown_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
            pins_q     <= pins_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            for (int unsigned k = 0; k < NUM_STEP; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
`ifdef PIN_DRIVER_STEP_COUNT_EN
                scnt_q[k]  <= scnt_d[k];
`endif
            end
        end
    end

    assign pins_out = pins_q;
    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;

endmodule

// File: tb/tb_pin_driver.sv
// Directed bench for pin_driver: Wishbone access, step pulse timing, overflow, shutdown, counters, reset.
module tb_pin_driver;

    localparam int NP = 8;
    localparam int NS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] step_pulse = '0;
    logic          pin_shutdown = 1'b0;
    logic [NP-1:0] pins_out;
    logic          wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]    wb_adr_i = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  pin_q [$];
    logic [31:0] rd;

    pin_driver #(.NUM_PINS(NP), .NUM_STEP(NS), .PW_W(8)) dut (
        .clk(clk), .rst(rst), .step_pulse(step_pulse), .pin_shutdown(pin_shutdown),
        .pins_out(pins_out), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n = 0;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
        do begin
            tick();
            n++;
        end while (!wb_ack_o && n < 8);
        check("ack_latency", 32'(n), 32'd1);
        rdat = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = '0;
        tick();
        check("ack_single", {31'b0, wb_ack_o}, 32'd0);
    endtask

    task automatic wb_write(input logic [3:0] adr, input logic [31:0] wdat);
        logic [31:0] r;
        wb_xfer(1'b1, adr, wdat, r);
    endtask

    task automatic wb_read(input string tag, input logic [3:0] adr, input logic [31:0] expv);
        logic [31:0] r;
        exp_q.push_back(expv);
        wb_xfer(1'b0, adr, 32'd0, r);
        check(tag, r, exp_q.pop_front());
    endtask

    // steps[i] drives step_pulse[0] into edge i; pattern[i] selects hi/lo expected after edge i.
    task automatic step_seq(input string tag, input int ncyc, input logic [31:0] steps,
                            input logic [31:0] pattern, input logic [7:0] lo, input logic [7:0] hi);
        for (int i = 0; i < ncyc; i++) begin
            step_pulse[0] = steps[i];
            pin_q.push_back(pattern[i] ? hi : lo);
            tick();
            step_pulse = '0;
            check($sformatf("%s[%0d]", tag, i), 32'(pins_out), 32'(pin_q.pop_front()));
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_pins", 32'(pins_out), 32'd0);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rst = 1'b0;
        tick();

        wb_write(4'd0, 32'h0000_00A5);
        check("pol_pins", 32'(pins_out), 32'h0000_00A5);
        wb_read("pol_read", 4'd0, 32'h0000_00A5);
        wb_write(4'd0, 32'h0);

        wb_write(4'd2, 32'd3);
        wb_read("pw_read", 4'd2, 32'd3);
        step_seq("pw3", 7, 32'h1, 32'h0E, 8'h00, 8'h01);
        wb_read("idle_status", 4'd3, 32'h0);

        wb_write(4'd0, 32'h1);
        step_seq("pw3_inv", 7, 32'h1, 32'h0E, 8'h01, 8'h00);
        wb_write(4'd0, 32'h0);

        wb_write(4'd2, 32'd0);
        step_seq("pw0", 4, 32'h1, 32'h2, 8'h00, 8'h01);

        wb_write(4'd2, 32'd3);
        step_seq("busy_pre", 2, 32'h1, 32'h2, 8'h00, 8'h01);
        wb_read("busy_status", 4'd3, 32'h0001_0000);
        for (int i = 0; i < 6; i++) tick();

        step_seq("ovf", 13, 32'h7, 32'h38E, 8'h00, 8'h01);
        wb_read("ovf_status", 4'd3, 32'h0000_0100);
        wb_write(4'd3, 32'h0000_0100);
        wb_read("ovf_cleared", 4'd3, 32'h0);

        wb_write(4'd4, 32'h0F);
        wb_read("safe_read", 4'd4, 32'h0F);
        step_seq("sd_pre", 2, 32'h1, 32'h2, 8'h00, 8'h01);
        pin_shutdown = 1'b1;
        tick();
        pin_shutdown = 1'b0;
        check("sd_pins", 32'(pins_out), 32'h0F);
        wb_read("sd_status", 4'd3, 32'h1);
        step_seq("sd_ignore", 4, 32'h5, 32'h0, 8'h0F, 8'h0F);
        pin_shutdown = 1'b1;
        wb_write(4'd3, 32'h1);
        pin_shutdown = 1'b0;
        wb_read("sd_race_status", 4'd3, 32'h1);
        wb_write(4'd3, 32'h1);
        check("sd_clear_pins", 32'(pins_out), 32'h0);
        wb_read("sd_clear_status", 4'd3, 32'h0);
        wb_write(4'd1, 32'h30);
        check("static_pins", 32'(pins_out), 32'h30);
        wb_write(4'd1, 32'h0);

        wb_write(4'd5, 32'hFFFF_FFFF);
        wb_read("unused_addr", 4'd5, 32'h0);

        wb_write(4'd8, 32'hFFFF_FFFE);
        step_seq("cnt_pulses", 24, 32'h0001_0101, 32'h000E_0E0E, 8'h00, 8'h01);
`ifdef PIN_DRIVER_STEP_COUNT_EN
        wb_read("step_count", 4'd8, 32'h0000_0001);
`else
        wb_read("step_count", 4'd8, 32'h0);
`endif

        wb_write(4'd0, 32'hFF);
        step_seq("rst_pre", 2, 32'h1, 32'h2, 8'hFF, 8'hFE);
        rst = 1'b1;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_adr_i = 4'd0;
        tick();
        check("midrst_pins", 32'(pins_out), 32'h0);
        check("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("midrst_dat", wb_dat_o, 32'h0);
        rst = 1'b0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        tick();
        check("postrst_pins", 32'(pins_out), 32'h0);
        check("postrst_ack", {31'b0, wb_ack_o}, 32'd0);
        wb_read("postrst_pol", 4'd0, 32'h0);
        wb_read("postrst_static", 4'd1, 32'h0);
        wb_read("postrst_pw", 4'd2, 32'h0);
        wb_read("postrst_status", 4'd3, 32'h0);
        wb_read("postrst_safe", 4'd4, 32'h0);
        wb_read("postrst_count", 4'd8, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
